// File: rtl/regfile_port_arbiter.sv
// Write-port owner for the 16x32 register file: clears every register after reset,
// then arbitrates writeback, long-latency results and debug accesses onto port 0.
module regfile_port_arbiter #(
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter int DW      = 32,
  parameter int MAXWAIT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_req,
  input  logic [AW-1:0] wb_adr,
  input  logic [DW-1:0] wb_data,
  output logic          wb_gnt,
  input  logic          lu_req,
  input  logic [AW-1:0] lu_adr,
  input  logic [DW-1:0] lu_data,
  output logic          lu_gnt,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_adr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  input  logic [DW-1:0] rf_rdata0,
  output logic          rf_wr,
  output logic          rf_ce,
  output logic [AW-1:0] rf_rno0,
  output logic [DW-1:0] rf_din,
  output logic          busy
);

  localparam int WW = (MAXWAIT < 2) ? 1 : $clog2(MAXWAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAXWAIT);
  localparam logic [AW-1:0] CLR_LAST = AW'(NREG - 1);

  typedef enum logic [1:0] {S_RST, S_CLR, S_RUN, S_DACK} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_clr_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic [DW-1:0] r_dbg_rdata;

  logic w_arb_en;
  logic w_lu_aged;
  logic w_gnt_wb;
  logic w_gnt_lu;
  logic w_gnt_dbg;

  // An aged long-latency result outranks writeback so it cannot starve.
  assign w_arb_en  = (r_state == S_RUN) || (r_state == S_DACK);
  assign w_lu_aged = lu_req && (r_wait_cnt == WAIT_MAX);
  assign w_gnt_lu  = w_arb_en && lu_req && (w_lu_aged || !wb_req);
  assign w_gnt_wb  = w_arb_en && wb_req && !w_lu_aged;
  assign w_gnt_dbg = (r_state == S_RUN) && dbg_req && !wb_req && !lu_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RST:   w_state_next = S_CLR;
      S_CLR:   w_state_next = (r_clr_cnt == CLR_LAST) ? S_RUN : S_CLR;
      S_RUN:   w_state_next = w_gnt_dbg ? S_DACK : S_RUN;
      S_DACK:  w_state_next = S_RUN;
      default: w_state_next = S_RST;
    endcase
  end

  always_comb begin
    wb_gnt  = w_gnt_wb;
    lu_gnt  = w_gnt_lu;
    dbg_ack = (r_state == S_DACK);
    rf_wr   = 1'b0;
    rf_ce   = 1'b0;
    rf_rno0 = wb_adr;
    rf_din  = '0;
    busy    = 1'b0;
    case (r_state)
      S_RST: begin
        rf_rno0 = '0;
        busy    = 1'b1;
      end
      S_CLR: begin
        rf_wr   = 1'b1;
        rf_ce   = 1'b1;
        rf_rno0 = r_clr_cnt;
        busy    = 1'b1;
      end
      default: begin
        if (w_gnt_lu) begin
          rf_wr   = 1'b1;
          rf_ce   = 1'b1;
          rf_rno0 = lu_adr;
          rf_din  = lu_data;
        end else if (w_gnt_wb) begin
          rf_wr   = 1'b1;
          rf_ce   = 1'b1;
          rf_rno0 = wb_adr;
          rf_din  = wb_data;
        end else if (w_gnt_dbg) begin
          rf_wr   = dbg_we;
          rf_ce   = 1'b1;
          rf_rno0 = dbg_adr;
          rf_din  = dbg_we ? dbg_wdata : '0;
        end
      end
    endcase
  end

  assign dbg_rdata = r_dbg_rdata;

  // Debug read data is captured from read port 0 at the end of its grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_clr_cnt <= (r_state == S_CLR) ? r_clr_cnt + 1'b1 : '0;
      if ((r_state == S_RST) || !lu_req || lu_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_MAX) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (w_gnt_dbg && !dbg_we) begin
        r_dbg_rdata <= rf_rdata0;
      end
    end
  end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Single-clock controller for the 16×32 triple-port register file. It owns the file's only write port, which is also the read-port-0 address.
- On reset it clears all registers to zero.
- It then arbitrates the write port among three requesters: pipeline writeback, the long-latency unit (mul/div result), and a debug read/write port.
- It drives the register file's `wr`, `ce`, `rno0` and `din`, and sits between the CPU pipeline and the register file.

## Interface
Parameters:
- `NREG`, 16, number of registers; the clear sequence covers 0..NREG-1.
- `AW`, 4, register address width.
- `DW`, 32, data width.
- `MAXWAIT`, 3, cycles the long-latency unit may wait before it outranks writeback.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `wb_req`  in  1  pipeline writeback request, valid for one cycle.
- `wb_adr`  in  AW  writeback register address.
- `wb_data`  in  DW  writeback data.
- `wb_gnt`  out  1  writeback written this cycle. If low while `wb_req`=1, the pipeline stalls and holds its request.
- `lu_req`  in  1  long-latency result request; held until granted.
- `lu_adr`  in  AW  long-latency result register address.
- `lu_data`  in  DW  long-latency result data.
- `lu_gnt`  out  1  long-latency result written this cycle.
- `dbg_req`  in  1  debug access request; held until `dbg_ack`.
- `dbg_we`  in  1  1 = debug write, 0 = debug read.
- `dbg_adr`  in  AW  debug register address.
- `dbg_wdata`  in  DW  debug write data.
- `dbg_ack`  out  1  one-cycle completion pulse (registered).
- `dbg_rdata`  out  DW  debug read result (registered); valid while `dbg_ack`=1 and held until the next debug read.
- `rf_rdata0`  in  DW  register file `dout0` (combinational read at `rf_rno0`).
- `rf_wr`  out  1  register file write enable.
- `rf_ce`  out  1  register file clock enable.
- `rf_rno0`  out  AW  register file write / read-port-0 address.
- `rf_din`  out  DW  register file write data.
- `busy`  out  1  high during RST and CLR; no grants are issued while it is high.

## Operation
FSM states: RST, CLR, RUN, DACK.

RST (entered asynchronously whenever `rst`=1):
- All grants, `rf_wr`, `rf_ce`, `dbg_ack` = 0.
- `rf_rno0` = 0, `rf_din` = 0, `busy` = 1.
- `dbg_rdata` = 0, clear counter = 0, wait counter = 0.
- First edge with `rst`=0 → CLR.

CLR:
- `rf_wr` = `rf_ce` = 1, `rf_rno0` = clear counter, `rf_din` = 0, `busy` = 1.
- Counter increments each cycle; after address NREG-1 is written → RUN.

RUN and DACK: combinational arbitration, one grant per cycle at most.
- Priority 1: `lu` when `lu_req`=1 and wait counter = MAXWAIT (aged).
- Priority 2: `wb`.
- Priority 3: `lu`.
- Priority 4: `dbg`, only in RUN; debug is never granted in DACK.

Effect of each grant:
- `wb` or `lu` grant: `rf_wr` = `rf_ce` = 1; `rf_rno0`/`rf_din` from the winner's address/data.
- Debug write grant: `rf_wr` = `rf_ce` = 1 with `dbg_adr`/`dbg_wdata`.
- Debug read grant: `rf_wr` = 0, `rf_ce` = 1, `rf_rno0` = `dbg_adr`; `rf_rdata0` is captured into `dbg_rdata` at the edge.
- Either debug grant: RUN → DACK. DACK asserts `dbg_ack`=1 for exactly one cycle, then → RUN.
- No grant: `rf_wr` = `rf_ce` = 0; `rf_rno0` = `wb_adr`, `rf_din` = 0.

Wait counter:
- Increments (saturating at MAXWAIT) each cycle with `lu_req`=1 and `lu_gnt`=0.
- Clears on `lu_gnt` or when `lu_req`=0.

Hazard ordering: same-address requests in one cycle are written in grant order, so the last grant wins. The controller does no RAW/WAW checking.

## Timing
- Register writes take effect at the edge ending the grant cycle; a read at that address sees the new value the following cycle.
- Clear: 1 cycle in RST after reset release, then NREG cycles in CLR. First grant possible in cycle NREG+1 after release (17 for the defaults).
- Worst-case `lu` latency while `wb` requests every cycle: MAXWAIT+1 cycles from `lu_req` to `lu_gnt`.
- Debug: grant in cycle N, `dbg_ack` in cycle N+1, next debug grant no earlier than N+2. Requester drops `dbg_req` in the ack cycle.
- `rst` asserted mid-CLR or mid-DACK: immediate return to RST. Clear restarts at 0, a pending `dbg_ack` is lost, and `dbg_rdata` = 0.

## Test plan
- Reset release, all requests low: `busy`=1 for 17 cycles. Writes of 0 to addresses 0..15 in order. `busy`=0 in cycle 17, then `rf_wr`=0 while idle.
- `wb_req` with adr=5, data=0xDEADBEEF, alone: `wb_gnt`=1 in the same cycle, `rf_wr`=1, `rf_rno0`=5. A debug read of r5 later returns 0xDEADBEEF.
- `wb_req` every cycle while `lu_req` is held (adr=3, data=0x12345678), MAXWAIT=3: `lu_gnt`=1 in the 4th cycle with `wb_gnt`=0 that cycle. `wb` resumes the next cycle.
- Debug write r7=0xA5A5A5A5, then debug read r7: each gives `dbg_ack` one cycle after grant. Read returns 0xA5A5A5A5. No debug grant while `wb_req` or `lu_req` is high.
- `wb_req` and `lu_req` both to r2 (0x1 and 0x2) in the same non-aged cycle: `wb` first, `lu` next, final r2=0x2.
- `rst` pulsed at CLR address 8 after r15 was previously written with 0xFF: clear restarts at 0, r15 reads 0 after completion, `busy` deasserts 17 cycles after release.
